keypad_key_history: RTL and testbench
=====================================

# keypad_key_history

Downstream consumer of the keypad scanner FSM. Debounces the scanner's key-valid/key-code pair and commits exactly one entry per physical press into a two-digit history (newest, previous). The history drives the dual seven-segment display path. The newest digit is fed back to the scanner as its `prev_num` input.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive sampled clock edges required to accept a press and to accept a release. Legal range is 2 or more. Benches use 4.

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `nrst`  in  1: reset, asynchronous, active-low.
- `key_valid`  in  1: from the scanner; high while the scanner reports a key down.
- `key_pressed`  in  4: from the scanner; hex code of the detected key; meaningful only while `key_valid` is high.
- `digit_new`  out  4: most recently committed key code.
- `digit_old`  out  4: key code committed before `digit_new`.
- `prev_num`  out  4: equals `digit_new`; feedback to the scanner.
- `new_key`  out  1: one-cycle pulse on commit.
- `key_held`  out  1: high in HELD and RELEASE.

## Operation
- States are IDLE, DEBOUNCE, HELD and RELEASE.
- Internal registers:
  - `cand` (4 bits): candidate code.
  - `cnt`: width `$clog2(DEBOUNCE_CYCLES+1)`; saturates and never wraps.
- IDLE:
  - `key_valid`=1 sampled: `cand`<=`key_pressed`, `cnt`<=1, go to DEBOUNCE.
  - Otherwise stay in IDLE.
- DEBOUNCE:
  - `key_valid`=0: return to IDLE. Nothing is committed.
  - `key_valid`=1 and `key_pressed`!=`cand`: `cand`<=`key_pressed`, `cnt`<=1, stay in DEBOUNCE (restart).
  - `key_valid`=1 and `key_pressed`==`cand` and `cnt`<`DEBOUNCE_CYCLES`-1: `cnt`++.
  - `key_valid`=1 and `key_pressed`==`cand` and `cnt`==`DEBOUNCE_CYCLES`-1: commit and go to HELD.
- Commit action:
  - `digit_old`<=`digit_new`.
  - `digit_new`<=`cand`.
  - `new_key`<=1.
  - The same code pressed twice is still committed twice, since each press is a separate event.
- HELD:
  - `key_valid`=1 with any code: stay in HELD. A code change is ignored; one key per press.
  - `key_valid`=0: `cnt`<=1, go to RELEASE.
- RELEASE:
  - `key_valid`=0 and `cnt`<`DEBOUNCE_CYCLES`-1: `cnt`++.
  - `key_valid`=0 and `cnt`==`DEBOUNCE_CYCLES`-1: go to IDLE.
  - `key_valid`=1 at any count: return to HELD, treated as bounce. No commit.
- Output derivation:
  - `new_key` is registered and cleared on every edge that does not commit.
  - `prev_num` is a wire copy of `digit_new`.
  - `key_held` decodes the state register.

## Timing
- Reset values, applied asynchronously on `nrst`=0:
  - state = IDLE, `cand`=0, `cnt`=0.
  - `digit_new`=0, `digit_old`=0, `prev_num`=0.
  - `new_key`=0, `key_held`=0.
- On `nrst` deassertion the block is in IDLE. A key already held at that point counts as a fresh press.
- Reset asserted mid-operation (any state, any count) aborts immediately. Any pending commit is lost.
- Press latency, with `key_valid` sampled high with a stable code on edges E0..E(N-1), where N=`DEBOUNCE_CYCLES`:
  - State leaves IDLE at E0.
  - Commit happens at E(N-1).
  - `digit_new`, `digit_old` and `new_key` change at E(N-1).
  - `new_key` falls at E(N).
  - `key_held` rises at E(N-1).
- Release latency, with `key_valid` sampled low on edges R0..R(N-1):
  - RELEASE is entered at R0.
  - IDLE is entered at R(N-1).
  - `key_held` falls at R(N-1).
  - The earliest next press is sampled at R(N).
- Maximum commit rate is one per 2N edges.
- There is no handshake and no backpressure. The consumer must sample `new_key` every cycle.

## Test plan
All scenarios use N=4.

1. Reset: drive `nrst`=0 mid-cycle with inputs toggling -> all outputs are 0 immediately. After release, with `key_valid`=0 for 10 cycles, there is no `new_key` pulse.
2. Clean press: `key_valid`=1, `key_pressed`=6 for 8 edges, then 0 for 8 edges -> exactly one `new_key` pulse at the 4th edge. After it, `digit_new`=6, `digit_old`=0, `prev_num`=6. `key_held` is high from the 4th edge until the 4th low edge.
3. History shift: press 6, fully release, then press 3 -> after the second commit, `digit_new`=3 and `digit_old`=6. Pressing 3 again gives `digit_new`=3 and `digit_old`=3.
4. Press bounce: `key_valid` pattern 1,1,0,1,1,1,1 with code 5 -> there is no commit after the first two highs. The commit is on the 4th high of the final run, giving `digit_new`=5.
5. Code glitch: code sequence 5,5,9,9,9,9 with `key_valid`=1 -> the counter restarts on the first 9. A single commit of 9 occurs on the 4th consecutive 9, and 5 is never committed.
6. Release bounce and held-change: hold 2 (committed), change the code to 8 while held, then `key_valid` pattern 0,0,1,0,0,0,0 -> no second `new_key`. `digit_new` stays 2. IDLE is reached only after the final four lows.

Source files
------------

// File: rtl/keypad_key_history.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_key_history
//  Description : Debounces the keypad scanner's key-valid/code pair and
//                commits one code per physical press into a two-digit
//                history (newest, previous). The newest digit is fed back
//                to the scanner as prev_num.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_key_history #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       key_valid,
  input  logic [3:0] key_pressed,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic [3:0] prev_num,
  output logic       new_key,
  output logic       key_held
);

  localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    digit_new_q, digit_new_d;
  logic [3:0]    digit_old_q, digit_old_d;
  logic          new_key_q, new_key_d;
  logic          commit;

  // State, candidate and debounce counter registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cand_q  <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: press/release debouncing and commit decision
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          cand_d  = key_pressed;
          cnt_d   = C_ONE;
          state_d = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (!key_valid) begin
          state_d = S_IDLE;
        end else if (key_pressed != cand_q) begin
          // A different code restarts the qualification window
          cand_d = key_pressed;
          cnt_d  = C_ONE;
        end else if (cnt_q < C_LAST) begin
          cnt_d = cnt_q + C_ONE;
        end else begin
          commit  = 1'b1;
          state_d = S_HELD;
        end
      end
      S_HELD: begin
        // Code changes while held are ignored: one key per press
        if (!key_valid) begin
          cnt_d   = C_ONE;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (key_valid) begin
          state_d = S_HELD;
        end else if (cnt_q < C_LAST) begin
          cnt_d = cnt_q + C_ONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // History shift and commit pulse
  always_comb begin
    digit_new_d = digit_new_q;
    digit_old_d = digit_old_q;
    new_key_d   = commit;
    if (commit) begin
      digit_old_d = digit_new_q;
      digit_new_d = cand_q;
    end
  end

  // History and pulse registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      digit_new_q <= 4'd0;
      digit_old_q <= 4'd0;
      new_key_q   <= 1'b0;
    end else begin
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
      new_key_q   <= new_key_d;
    end
  end

  // Output decode: held flag from state, history straight from registers
  always_comb begin
    key_held  = (state_q == S_HELD) || (state_q == S_RELEASE);
    digit_new = digit_new_q;
    digit_old = digit_old_q;
    prev_num  = digit_new_q;
    new_key   = new_key_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_key_history.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_key_history
//  Description : Self-checking bench for keypad_key_history with N = 4.
//                A run-length model of press/release qualification is
//                compared against the DUT every cycle, plus literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_key_history;

  localparam int N = 4;

  logic       clk;
  logic       nrst;
  logic       key_valid;
  logic [3:0] key_pressed;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic [3:0] prev_num;
  logic       new_key;
  logic       key_held;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;

  keypad_key_history #(.DEBOUNCE_CYCLES(N)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .key_valid  (key_valid),
    .key_pressed(key_pressed),
    .digit_new  (digit_new),
    .digit_old  (digit_old),
    .prev_num   (prev_num),
    .new_key    (new_key),
    .key_held   (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Not pressed: count consecutive high samples carrying the same code;
  // the N-th such sample commits. Pressed: count consecutive low samples;
  // the N-th ends the press.
  logic       m_pressed;
  int         m_run;
  logic [3:0] m_code;
  int         m_low;
  logic [3:0] m_new, m_old;
  logic       m_pulse;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_pressed = 1'b0; m_run = 0; m_code = 4'd0; m_low = 0;
      m_new = 4'd0; m_old = 4'd0; m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      if (!m_pressed) begin
        if (key_valid) begin
          if (m_run > 0 && key_pressed == m_code) m_run = m_run + 1;
          else begin m_code = key_pressed; m_run = 1; end
          if (m_run == N) begin
            m_old = m_new; m_new = m_code; m_pulse = 1'b1;
            m_pressed = 1'b1; m_low = 0;
          end
        end else begin
          m_run = 0;
        end
      end else begin
        if (key_valid) m_low = 0;
        else m_low = m_low + 1;
        if (m_low == N) begin m_pressed = 1'b0; m_run = 0; end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("digit_new", digit_new, m_new);
    chk("digit_old", digit_old, m_old);
    chk("prev_num",  prev_num,  m_new);
    chk("new_key",   {3'b0, new_key},  {3'b0, m_pulse});
    chk("key_held",  {3'b0, key_held}, {3'b0, m_pressed});
    if (new_key) pulses++;
  end

  // Drive one sample, then wait until just after the edge that takes it
  task automatic step(input logic kv, input logic [3:0] code);
    key_valid   = kv;
    key_pressed = code;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  int p0;

  initial begin
    nrst = 1'b0; key_valid = 1'b0; key_pressed = 4'd0;
    // 1. reset with toggling inputs, release mid-cycle
    for (int i = 0; i < 4; i++) step(i[0], 4'(i + 5));
    chk("rst_digit_new", digit_new, 4'd0);
    chk("rst_new_key", {3'b0, new_key}, 4'd0);
    #2 nrst = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 4'd0);
    chk("idle_no_pulse", 4'(pulses), 4'd0);

    // 2. clean press of 6
    p0 = pulses;
    for (int i = 0; i < 3; i++) step(1'b1, 4'd6);
    chk("press6_pre_commit", {3'b0, new_key}, 4'd0);
    step(1'b1, 4'd6);
    chk("press6_pulse", {3'b0, new_key}, 4'd1);
    chk("press6_new", digit_new, 4'd6);
    chk("press6_old", digit_old, 4'd0);
    chk("press6_prev", prev_num, 4'd6);
    chk("press6_held", {3'b0, key_held}, 4'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 4'd6);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0);
    chk("rel6_still_held", {3'b0, key_held}, 4'd1);
    step(1'b0, 4'd0);
    chk("rel6_released", {3'b0, key_held}, 4'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0);
    chk("press6_one_pulse", 4'(pulses - p0), 4'd1);

    // 3. history shift
    for (int i = 0; i < 5; i++) step(1'b1, 4'd3);
    for (int i = 0; i < 5; i++) step(1'b0, 4'd0);
    chk("hist_new3", digit_new, 4'd3);
    chk("hist_old6", digit_old, 4'd6);
    for (int i = 0; i < 5; i++) step(1'b1, 4'd3);
    for (int i = 0; i < 5; i++) step(1'b0, 4'd0);
    chk("hist2_new3", digit_new, 4'd3);
    chk("hist2_old3", digit_old, 4'd3);

    // 4. press bounce 1,1,0,1,1,1,1 code 5
    p0 = pulses;
    step(1'b1, 4'd5); step(1'b1, 4'd5); step(1'b0, 4'd5);
    step(1'b1, 4'd5); step(1'b1, 4'd5); step(1'b1, 4'd5);
    chk("bounce_no_commit", 4'(pulses - p0), 4'd0);
    step(1'b1, 4'd5);
    chk("bounce_commit_pulse", {3'b0, new_key}, 4'd1);
    chk("bounce_new5", digit_new, 4'd5);
    for (int i = 0; i < 5; i++) step(1'b0, 4'd0);

    // 5. code glitch 5,5,9,9,9,9
    p0 = pulses;
    step(1'b1, 4'd5); step(1'b1, 4'd5);
    step(1'b1, 4'd9); step(1'b1, 4'd9); step(1'b1, 4'd9);
    chk("glitch_pre", 4'(pulses - p0), 4'd0);
    step(1'b1, 4'd9);
    chk("glitch_new9", digit_new, 4'd9);
    chk("glitch_old5", digit_old, 4'd5);
    for (int i = 0; i < 5; i++) step(1'b0, 4'd0);
    chk("glitch_one_pulse", 4'(pulses - p0), 4'd1);

    // 6. hold 2, change to 8 while held, release bounce
    p0 = pulses;
    for (int i = 0; i < 4; i++) step(1'b1, 4'd2);
    for (int i = 0; i < 3; i++) step(1'b1, 4'd8);
    step(1'b0, 4'd0); step(1'b0, 4'd0); step(1'b1, 4'd8);
    step(1'b0, 4'd0); step(1'b0, 4'd0); step(1'b0, 4'd0);
    chk("relb_still_held", {3'b0, key_held}, 4'd1);
    step(1'b0, 4'd0);
    chk("relb_idle", {3'b0, key_held}, 4'd0);
    chk("relb_new2", digit_new, 4'd2);
    chk("relb_one_pulse", 4'(pulses - p0), 4'd1);

    // 7. reset mid-press, key held through reset counts as fresh press
    for (int i = 0; i < 2; i++) step(1'b1, 4'd7);
    #2 key_valid = 1'b0; nrst = 1'b0;
    #1;
    chk("midrst_new", digit_new, 4'd0);
    chk("midrst_old", digit_old, 4'd0);
    chk("midrst_held", {3'b0, key_held}, 4'd0);
    key_valid = 1'b1; key_pressed = 4'd7;
    @(posedge clk); #3 nrst = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 4; i++) step(1'b1, 4'd7);
    chk("fresh_new7", digit_new, 4'd7);
    chk("fresh_old0", digit_old, 4'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 4'd0);
    chk("fresh_one_pulse", 4'(pulses - p0), 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
